// File: rtl/weight_loader.sv
// Weight-bank fill stage: round-robins a valid/ready byte stream across NUM_BANKS banks.
// Optional feature: define WEIGHT_LOADER_CHECKSUM_EN to build the 16-bit byte-sum accumulator.
module weight_loader #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BANK_BITS  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [3:0]              layer_id,
  input  logic [ADDR_WIDTH:0]     word_count,
  input  logic                    abort,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    in_ready,
  output logic [(1<<BANK_BITS)-1:0] csen,
  output logic                    wrenb,
  output logic [ADDR_WIDTH-1:0]   addr_b,
  output logic [DATA_WIDTH-1:0]   data_b,
  output logic [3:0]              layer2weight_cnt,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [15:0]             checksum
);

  localparam int unsigned NUM_BANKS = 1 << BANK_BITS;
  localparam int unsigned KW        = ADDR_WIDTH + BANK_BITS + 1;

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e state_q, state_d;

  logic [KW-1:0]           k_q;
  logic [ADDR_WIDTH:0]     wc_q;
  logic [3:0]              layer_q;
  logic                    wr_q, wr_d;
  logic [NUM_BANKS-1:0]    csen_q, csen_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic          accept;
  logic          start_ok;
  logic [KW-1:0] total;
  logic          last;

  assign accept   = in_valid && in_ready;
  assign start_ok = (state_q == StIdle) && start;
  assign total    = {wc_q, {BANK_BITS{1'b0}}};
  assign last     = (k_q == total - KW'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (word_count == '0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        if (abort) begin
          state_d = StIdle;
        end else if (accept && last) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic: in_ready is the only combinational output; the rest feed registers
  always_comb begin
    in_ready = (state_q == StLoad) && !abort;
    busy_d   = (state_d == StLoad);
    done_d   = (state_d == StDone);
    err_d    = (state_q == StLoad) && abort;
    wr_d     = 1'b0;
    csen_d   = '0;
    addr_d   = '0;
    data_d   = '0;
    if (accept) begin
      wr_d   = 1'b1;
      csen_d = NUM_BANKS'(1) << k_q[BANK_BITS-1:0];
      addr_d = k_q[KW-2:BANK_BITS];
      data_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      csen_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      k_q     <= '0;
      wc_q    <= '0;
      layer_q <= '0;
    end else begin
      wr_q    <= wr_d;
      csen_q  <= csen_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (start_ok) begin
        k_q     <= '0;
        wc_q    <= word_count;
        layer_q <= layer_id;
      end else if (accept) begin
        k_q <= k_q + KW'(1);
      end
    end
  end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (start_ok) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= sum_q + 16'(in_data);
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

  assign wrenb            = wr_q;
  assign csen             = csen_q;
  assign addr_b           = addr_q;
  assign data_b           = data_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;
  assign layer2weight_cnt = layer_q;

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: expected writes queued at drive time, popped on wrenb.
module tb_weight_loader;

  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  layer_id = '0;
  logic [11:0] word_count = '0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic [3:0]  csen;
  logic        wrenb;
  logic [10:0] addr_b;
  logic [7:0]  data_b;
  logic [3:0]  layer2weight_cnt;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] checksum;

  always #5 clk = ~clk;

  weight_loader #(
    .ADDR_WIDTH (11),
    .DATA_WIDTH (8),
    .BANK_BITS  (2)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .layer_id         (layer_id),
    .word_count       (word_count),
    .abort            (abort),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_ready         (in_ready),
    .csen             (csen),
    .wrenb            (wrenb),
    .addr_b           (addr_b),
    .data_b           (data_b),
    .layer2weight_cnt (layer2weight_cnt),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .checksum         (checksum)
  );

  typedef struct packed {
    logic [3:0]  csen;
    logic [10:0] addr;
    logic [7:0]  data;
    logic        last;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         got;
  int          checks = 0;
  int          errors = 0;
  int          n_wr = 0;
  int          n_pushed = 0;
  int          n_done = 0;
  int          n_err = 0;
  logic [3:0]  last_csen = '0;
  logic [10:0] last_addr = '0;
  logic [15:0] sum_model = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Monitor samples on the falling edge, well away from input changes
  always @(negedge clk) begin
    if (rst_n) begin
      if (wrenb) begin
        n_wr++;
        last_csen = csen;
        last_addr = addr_b;
        if (exp_q.size() == 0) begin
          check_eq("extra_write", n_wr, n_pushed);
        end else begin
          got = exp_q.pop_front();
          check_eq("csen", csen, got.csen);
          check_eq("addr_b", addr_b, got.addr);
          check_eq("data_b", data_b, got.data);
          check_eq("done_on_write", done, got.last);
        end
      end else begin
        check_eq("idle_write_bus", {csen, addr_b, data_b}, 0);
      end
      if (done) begin
        n_done++;
        check_eq("busy_at_done", busy, 0);
      end
      if (err) n_err++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] lid, input logic [11:0] wc);
    start      = 1'b1;
    layer_id   = lid;
    word_count = wc;
    tick();
    start     = 1'b0;
    sum_model = '0;
  endtask

  task automatic send(input logic [7:0] d, input int idx, input int total);
    wr_t e;
    in_valid = 1'b1;
    in_data  = d;
    e.csen = 4'(1 << (idx % NB));
    e.addr = 11'(idx / NB);
    e.data = d;
    e.last = (idx == total - 1);
    exp_q.push_back(e);
    n_pushed++;
    sum_model = sum_model + 16'(d);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load(input logic [3:0] lid, input int wc, input bit gap, input int mul);
    int total;
    total = wc * NB;
    do_start(lid, 12'(wc));
    for (int i = 0; i < total; i++) begin
      if (gap && (i % 2 == 1)) tick();
      send(8'(i * mul + 1), i, total);
    end
    tick();
    tick();
  endtask

  function automatic logic [15:0] exp_sum();
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    return sum_model;
`else
    return 16'h0;
`endif
  endfunction

  int d0, w0, e0;

  initial begin
    // Reset and idle
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check_eq("rst_wrenb", wrenb, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_layer", layer2weight_cnt, 0);
    check_eq("rst_checksum", checksum, 0);

    // Back-to-back load, 12 bytes 0x01..0x0C
    d0 = n_done; w0 = n_wr;
    load(4'd5, 3, 1'b0, 1);
    check_eq("b2b_layer", layer2weight_cnt, 5);
    check_eq("b2b_checksum", checksum, exp_sum());
    check_eq("b2b_done_cnt", n_done - d0, 1);
    check_eq("b2b_writes", n_wr - w0, 12);
    check_eq("b2b_queue", exp_q.size(), 0);
    check_eq("b2b_busy", busy, 0);

    // Same load with bubbles
    d0 = n_done; w0 = n_wr;
    load(4'd9, 3, 1'b1, 1);
    check_eq("gap_layer", layer2weight_cnt, 9);
    check_eq("gap_checksum", checksum, exp_sum());
    check_eq("gap_done_cnt", n_done - d0, 1);
    check_eq("gap_writes", n_wr - w0, 12);
    check_eq("gap_queue", exp_q.size(), 0);

    // Abort together with the 5th byte
    d0 = n_done; w0 = n_wr; e0 = n_err;
    do_start(4'd2, 12'd3);
    for (int i = 0; i < 4; i++) send(8'(i + 1), i, 12);
    in_valid = 1'b1;
    in_data  = 8'd5;
    abort    = 1'b1;
    #1;
    check_eq("abort_in_ready", in_ready, 0);
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    check_eq("abort_err_cnt", n_err - e0, 1);
    check_eq("abort_done_cnt", n_done - d0, 0);
    check_eq("abort_writes", n_wr - w0, 4);
    check_eq("abort_queue", exp_q.size(), 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_checksum", checksum, exp_sum());

    // word_count = 0
    d0 = n_done; w0 = n_wr;
    do_start(4'd1, 12'd0);
    check_eq("wc0_done", done, 1);
    check_eq("wc0_busy", busy, 0);
    tick();
    check_eq("wc0_done_fall", done, 0);
    tick();
    check_eq("wc0_done_cnt", n_done - d0, 1);
    check_eq("wc0_writes", n_wr - w0, 0);

    // start during LOAD is ignored
    d0 = n_done;
    do_start(4'd3, 12'd1);
    send(8'hA0, 0, 4);
    start      = 1'b1;
    layer_id   = 4'd7;
    word_count = 12'd5;
    send(8'hA1, 1, 4);
    start = 1'b0;
    send(8'hA2, 2, 4);
    send(8'hA3, 3, 4);
    tick();
    tick();
    check_eq("ign_layer", layer2weight_cnt, 3);
    check_eq("ign_done_cnt", n_done - d0, 1);
    check_eq("ign_queue", exp_q.size(), 0);
    check_eq("ign_checksum", checksum, exp_sum());

    // Full-depth load
    d0 = n_done; w0 = n_wr;
    load(4'd11, 2048, 1'b0, 7);
    check_eq("full_last_csen", last_csen, 4'b1000);
    check_eq("full_last_addr", last_addr, 11'h7FF);
    check_eq("full_writes", n_wr - w0, 8192);
    check_eq("full_done_cnt", n_done - d0, 1);
    check_eq("full_queue", exp_q.size(), 0);
    check_eq("full_checksum", checksum, exp_sum());

    // Asynchronous reset mid-load
    do_start(4'd6, 12'd2048);
    for (int i = 0; i < 100; i++) send(8'(i + 3), i, 8192);
    rst_n = 1'b0;
    #1;
    check_eq("arst_wrenb", wrenb, 0);
    check_eq("arst_bus", {csen, addr_b, data_b}, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_layer", layer2weight_cnt, 0);
    check_eq("arst_checksum", checksum, 0);
    check_eq("arst_in_ready", in_ready, 0);
    exp_q.delete();
    n_pushed = n_wr;
    tick();
    rst_n = 1'b1;
    tick();
    d0 = n_done;
    load(4'd4, 1, 1'b0, 3);
    check_eq("post_rst_layer", layer2weight_cnt, 4);
    check_eq("post_rst_done_cnt", n_done - d0, 1);
    check_eq("post_rst_queue", exp_q.size(), 0);
    check_eq("post_rst_checksum", checksum, exp_sum());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
